mmio_io_unit: RTL
=================

Name: mmio_io_unit

Overview:
- Memory-mapped I/O back end for the RISC-V core. It consumes the one-hot I/O selects produced by the memory-control decoder in WB.
- Holds the cycle and instruction counters and a small UART TX FIFO. It performs the ready/valid handshakes with the UART.
- Returns 32-bit load data for I/O addresses 0x80000000–0x80000018 to the WB write-back mux.

Parameters:
TX_DEPTH, 4, TX FIFO entries (power of 2, ≥2)
CTR_WIDTH, 32, width of cycle/instruction counters (read zero-extended to 32)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
io_en  in  1  I/O access this cycle (WB)
uart_control  in  1  read status select (0x80000000)
uart_rec  in  1  read RX data select (0x80000004)
uart_tran  in  1  write TX data select (0x80000008)
cycle_ctr  in  1  read cycle counter select (0x80000010)
instr_ctr  in  1  read instruction counter select (0x80000014)
reset_ctr  in  1  counter reset select (0x80000018)
wdata  in  32  store data in WB (byte [7:0] used for TX)
instr_retire  in  1  a non-bubble instruction completes WB this cycle
uart_tx_data_in  out  8  byte to UART TX
uart_tx_data_in_valid  out  1  TX byte valid
uart_tx_data_in_ready  in  1  UART TX accepts byte
uart_rx_data_out  in  8  byte from UART RX
uart_rx_data_out_valid  in  1  RX byte available
uart_rx_data_out_ready  out  1  pop RX byte
io_rdata  out  32  load data for selected I/O register

Behaviour:
- Reset (rst=1 at a clock edge): cycle count=0, instr count=0, TX FIFO empty (pointers=0), uart_tx_data_in_valid=0. Reset aborts any pending TX entries; no byte is emitted afterwards.
- Cycle counter: increments by 1 every clock, wraps from 2^CTR_WIDTH−1 to 0.
- Instr counter: +1 on any cycle with instr_retire=1; wraps identically.
- Counter reset: when io_en&reset_ctr, both counters load 0 at the next edge. This has priority over the same-cycle increment and retire, so the value after the edge is 0, not 1.
- Reads are combinational from registered state (zero added latency), so the value is usable by WB in the same cycle.
  - uart_control: io_rdata = {30'b0, uart_rx_data_out_valid, !tx_full}.
  - uart_rec: io_rdata = {24'b0, uart_rx_data_out}, and uart_rx_data_out_ready=1 for exactly that cycle. Reading with valid=0 returns the current byte and has no side effect beyond the ready pulse.
  - cycle_ctr/instr_ctr: io_rdata = current register value (pre-increment), zero-extended.
  - No select, or io_en=0: io_rdata=0 and uart_rx_data_out_ready=0.
  - Selects are one-hot by construction upstream. If several are asserted anyway, priority is uart_control > uart_rec > cycle_ctr > instr_ctr.
- TX write (io_en&uart_tran):
  - Not full: push wdata[7:0] at the edge.
  - Full: the write is dropped silently; software must poll the status bit.
- TX drain:
  - uart_tx_data_in = FIFO head; uart_tx_data_in_valid = !empty.
  - valid&ready pops the head at the edge.
  - Data/valid must stay stable while ready=0.
- Simultaneous push and pop:
  - When full: the pop frees space and the push is accepted; occupancy unchanged.
  - When empty: the push is not visible on valid until the next cycle (no bypass).
- Pointers are log2(TX_DEPTH)+1 bits; full/empty come from MSB compare; wrap-around is natural.
- The first push after reset appears on uart_tx_data_in_valid one cycle later.

Decomposition:
- Package io_pkg holds:
  - address localparams: IO_UART_CTRL=0x80000000, IO_UART_RX=0x80000004, IO_UART_TX=0x80000008, IO_CYCLE=0x80000010, IO_INSTR=0x80000014, IO_CTR_RST=0x80000018;
  - status bit indices: RX_VALID_BIT=1, TX_READY_BIT=0.
- One sub-module, io_tx_fifo: synchronous FIFO parameterised by DEPTH and WIDTH=8, with push/pop/full/empty/head. Counters and the read mux stay in the top.

Test Plan:
- Reset, then run 100 cycles idle with instr_retire=0 → cycle read = 100 (±read-cycle offset checked exactly against the model), instr read = 0, tx_valid=0.
- instr_retire high for 37 cycles, then io_en&reset_ctr in the same cycle as instr_retire=1 → next-cycle reads give cycle=0 and instr=0. Counters then resume from 1.
- Push 0x41,0x42,0x43,0x44 with ready=0 → status bit0=0 (full). A 5th push of 0x45 is dropped. Raise ready → exactly 0x41..0x44 emitted in order, one per cycle, then valid=0 and status bit0=1.
- FIFO full, push 0x55 in the same cycle as a valid&ready pop → 0x55 is accepted and emitted last; no loss or duplication.
- RX valid=1 with byte 0xA5: status read → 0x00000002|tx_ready. RX data read → io_rdata=0x000000A5 and a one-cycle uart_rx_data_out_ready pulse. No pulse on the status read.
- Force cycle counter to 0xFFFFFFFE, step 2 cycles → reads 0xFFFFFFFF then 0x00000000. Assert rst with 2 TX bytes pending → valid=0 next cycle and nothing further is emitted.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared addresses, status bit positions and read-select decode for the MMIO I/O unit
package io_pkg;

    localparam logic [31:0] IO_UART_CTRL = 32'h8000_0000;
    localparam logic [31:0] IO_UART_RX   = 32'h8000_0004;
    localparam logic [31:0] IO_UART_TX   = 32'h8000_0008;
    localparam logic [31:0] IO_CYCLE     = 32'h8000_0010;
    localparam logic [31:0] IO_INSTR     = 32'h8000_0014;
    localparam logic [31:0] IO_CTR_RST   = 32'h8000_0018;

    localparam int RX_VALID_BIT = 1;
    localparam int TX_READY_BIT = 0;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_STATUS,
        SEL_RX,
        SEL_CYCLE,
        SEL_INSTR
    } rd_sel_e;

    // Selects should be one-hot, but resolve overlaps deterministically.
    function automatic rd_sel_e pick_read(input logic en, input logic ctrl, input logic rec,
                                          input logic cyc, input logic ins);
        if (!en)       return SEL_NONE;
        else if (ctrl) return SEL_STATUS;
        else if (rec)  return SEL_RX;
        else if (cyc)  return SEL_CYCLE;
        else if (ins)  return SEL_INSTR;
        else           return SEL_NONE;
    endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// rtl/io_tx_fifo.sv - small synchronous FIFO with wrap-bit pointers feeding the UART transmitter
module io_tx_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign head  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_io_unit.sv
// rtl/mmio_io_unit.sv - MMIO back end: cycle/instr counters, UART TX FIFO and combinational load mux
module mmio_io_unit
    import io_pkg::*;
#(
    parameter int TX_DEPTH  = 4,
    parameter int CTR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_en,
    input  logic        uart_control,
    input  logic        uart_rec,
    input  logic        uart_tran,
    input  logic        cycle_ctr,
    input  logic        instr_ctr,
    input  logic        reset_ctr,
    input  logic [31:0] wdata,
    input  logic        instr_retire,
    output logic [7:0]  uart_tx_data_in,
    output logic        uart_tx_data_in_valid,
    input  logic        uart_tx_data_in_ready,
    input  logic [7:0]  uart_rx_data_out,
    input  logic        uart_rx_data_out_valid,
    output logic        uart_rx_data_out_ready,
    output logic [31:0] io_rdata
);

    logic [CTR_WIDTH-1:0] r_cycle;
    logic [CTR_WIDTH-1:0] r_instr;
    logic                 w_tx_full;
    logic                 w_tx_empty;
    logic                 w_ctr_clear;
    rd_sel_e              w_sel;
    logic                 w_unused;

    assign w_unused    = &{1'b0, wdata[31:8]};
    assign w_ctr_clear = io_en && reset_ctr;

    always_ff @(posedge clk) begin
        if (rst || w_ctr_clear) begin
            r_cycle <= '0;
            r_instr <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (instr_retire) r_instr <= r_instr + 1'b1;
        end
    end

    io_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (io_en && uart_tran),
        .push_data (wdata[7:0]),
        .pop       (uart_tx_data_in_valid && uart_tx_data_in_ready),
        .full      (w_tx_full),
        .empty     (w_tx_empty),
        .head      (uart_tx_data_in)
    );

    assign uart_tx_data_in_valid = !w_tx_empty;

    assign w_sel = pick_read(io_en, uart_control, uart_rec, cycle_ctr, instr_ctr);

    always_comb begin
        io_rdata               = '0;
        uart_rx_data_out_ready = 1'b0;
        case (w_sel)
            SEL_STATUS: begin
                io_rdata[RX_VALID_BIT] = uart_rx_data_out_valid;
                io_rdata[TX_READY_BIT] = !w_tx_full;
            end
            SEL_RX: begin
                io_rdata[7:0]          = uart_rx_data_out;
                uart_rx_data_out_ready = 1'b1;
            end
            SEL_CYCLE: io_rdata = 32'(r_cycle);
            SEL_INSTR: io_rdata = 32'(r_instr);
            default:   io_rdata = '0;
        endcase
    end

endmodule
